// File: rtl/tdm_demux_4bit_pkg.sv
// Shared definitions for the TDM 4-bit receive demultiplexer.
// Slot-tracking state encodings and the default bus width.
package tdm_demux_4bit_pkg;

  localparam int unsigned TDM_WIDTH = 4;

  // 2'b11 is unused and falls back to ST_HUNT on the next clock.
  typedef enum logic [1:0] {
    ST_HUNT  = 2'b00,
    ST_EXP_B = 2'b01,
    ST_EXP_A = 2'b10
  } tdm_state_t;

endpackage

// File: rtl/reg_en_4bit.sv
// Enabled data register with asynchronous active-low clear.
// One instance holds each demultiplexed output channel.
module reg_en_4bit
  import tdm_demux_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = TDM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/tdm_demux_4bit.sv
// Receive side of an A/B time-division-multiplexed 4-bit bus: steers each
// word into its own registered channel, tracks slot alignment and flags errors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_HUNT  | not aligned; waiting for a sync-marked (channel-A) beat
// ST_EXP_B | A word captured; next beat should be channel B (sync=0)
// ST_EXP_A | B word captured; next beat should be channel A (sync=1)
module tdm_demux_4bit
  import tdm_demux_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = TDM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] ya,
  output logic [WIDTH-1:0] yb,
  output logic             ya_valid,
  output logic             yb_valid,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  tdm_state_t r_state;
  tdm_state_t w_state_nxt;
  logic       w_load_a;
  logic       w_load_b;
  logic       w_err;
  logic       r_ya_valid;
  logic       r_yb_valid;
  logic       r_frame_valid;
  logic       r_sync_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (din_valid && sync) begin
          w_load_a    = 1'b1;
          w_state_nxt = ST_EXP_B;
        end
      end
      ST_EXP_B: begin
        if (din_valid) begin
          if (sync) begin
            // B slot missing: the new A word still replaces the old one.
            w_err    = 1'b1;
            w_load_a = 1'b1;
          end else begin
            w_load_b    = 1'b1;
            w_state_nxt = ST_EXP_A;
          end
        end
      end
      ST_EXP_A: begin
        if (din_valid) begin
          if (sync) begin
            w_load_a    = 1'b1;
            w_state_nxt = ST_EXP_B;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_HUNT;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ya_valid    <= 1'b0;
      r_yb_valid    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_ya_valid    <= w_load_a;
      r_yb_valid    <= w_load_b;
      r_frame_valid <= w_load_b;
      r_sync_err    <= w_err;
    end
  end

  reg_en_4bit #(.WIDTH(WIDTH)) u_reg_ya (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_load_a),
    .d     (din),
    .q     (ya)
  );

  reg_en_4bit #(.WIDTH(WIDTH)) u_reg_yb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_load_b),
    .d     (din),
    .q     (yb)
  );

  assign ya_valid    = r_ya_valid;
  assign yb_valid    = r_yb_valid;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = (r_state != ST_HUNT);

endmodule

// File: tb/tb_tdm_demux_4bit.sv
// Bench for tdm_demux_4bit: directed frame scenarios followed by random
// beats, compared against a slot-level behavioural model.
module tb_tdm_demux_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       sync;
  logic [3:0] ya;
  logic [3:0] yb;
  logic       ya_valid;
  logic       yb_valid;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  int n_chk  = 0;
  int n_pass = 0;

  // model: aligned flag, and whether the next expected slot is B
  bit       m_aligned;
  bit       m_want_b;
  bit [3:0] m_ya, m_yb;
  bit       m_va, m_vb, m_fv, m_err;

  tdm_demux_4bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .ya          (ya),
    .yb          (yb),
    .ya_valid    (ya_valid),
    .yb_valid    (yb_valid),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic chk_all(input string tag);
    chk_eq({tag, ".ya"},          32'(ya),          32'(m_ya));
    chk_eq({tag, ".yb"},          32'(yb),          32'(m_yb));
    chk_eq({tag, ".ya_valid"},    32'(ya_valid),    32'(m_va));
    chk_eq({tag, ".yb_valid"},    32'(yb_valid),    32'(m_vb));
    chk_eq({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk_eq({tag, ".locked"},      32'(locked),      32'(m_aligned));
    chk_eq({tag, ".sync_err"},    32'(sync_err),    32'(m_err));
  endtask

  task automatic mdl_reset();
    m_aligned = 0; m_want_b = 0;
    m_ya = '0; m_yb = '0;
    m_va = 0; m_vb = 0; m_fv = 0; m_err = 0;
  endtask

  task automatic mdl_beat(input bit v, input bit [3:0] d, input bit s);
    m_va = 0; m_vb = 0; m_fv = 0; m_err = 0;
    if (!v) return;
    if (!m_aligned) begin
      if (s) begin m_ya = d; m_va = 1; m_aligned = 1; m_want_b = 1; end
    end else if (m_want_b) begin
      if (!s) begin m_yb = d; m_vb = 1; m_fv = 1; m_want_b = 0; end
      else begin m_err = 1; m_ya = d; m_va = 1; end
    end else begin
      if (s) begin m_ya = d; m_va = 1; m_want_b = 1; end
      else begin m_err = 1; m_aligned = 0; end
    end
  endtask

  // Called at a falling edge; drives a cycle, checks after the rising edge.
  task automatic step(input string tag, input bit v, input bit [3:0] d, input bit s);
    din_valid = v; din = d; sync = s;
    mdl_beat(v, d, s);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 4'($urandom), 1'($urandom));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    mdl_reset();
    #1 chk_all({tag, ".async"});
    din_valid = 1'($urandom); din = 4'($urandom); sync = 1'($urandom);
    @(negedge clk);
    chk_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; din_valid = 1'b1; din = 4'hF; sync = 1'b1;
    mdl_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din = 4'($urandom); din_valid = 1'($urandom); sync = 1'($urandom);
      chk_all("rst_hold");
    end
    rst_n = 1'b1;
    idle("rst_idle", 3);

    // clean back-to-back frames
    step("clean0", 1, 4'hA, 1);
    step("clean1", 1, 4'h5, 0);
    step("clean2", 1, 4'h3, 1);
    step("clean3", 1, 4'hC, 0);

    // same frames with gaps and junk on din/sync between beats
    step("gap0", 1, 4'hA, 1); idle("gap_i0", 2);
    step("gap1", 1, 4'h5, 0); idle("gap_i1", 1);
    step("gap2", 1, 4'h3, 1); idle("gap_i2", 3);
    step("gap3", 1, 4'hC, 0); idle("gap_i3", 1);

    // missing B slot while locked
    step("missb0", 1, 4'h1, 1);
    step("missb1", 1, 4'h2, 1);
    step("missb2", 1, 4'h4, 0);

    // lost sync after a B beat, then relock
    step("lost0", 1, 4'h7, 0);
    step("lost1", 1, 4'hB, 0);
    step("lost2", 1, 4'h9, 1);

    // reset mid-frame while expecting B
    async_reset("midrst");
    step("midrst0", 1, 4'h6, 0);
    step("midrst1", 1, 4'hE, 1);
    step("midrst2", 1, 4'hD, 0);

    // random beats, mostly well-formed with occasional slot errors
    for (int i = 0; i < 2000; i++) begin
      int unsigned r;
      bit s;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        async_reset("rnd_rst");
      end else begin
        s = ($urandom_range(0, 9) < 2) ? 1'($urandom) : ((m_aligned && m_want_b) ? 1'b0 : 1'b1);
        step("rnd", r < 70, 4'($urandom), s);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
